piezo_mon: RTL and testbench
============================

Name: piezo_mon

Overview:
- Receive-side decoder for the piezo alert line. Samples the square wave on piezo, measures each period and classifies it into one of the four notes (G6, C7, E7, G7).
- Groups consecutive same-note periods into notes, then identifies the complete melody once the line goes silent: steer-enable, too-fast or battery-low.
- Sits beside the piezo driver and serves as a built-in self-test monitor and as a scoreboard front-end for the full-chip bench.

Parameters:
- P_G6  32  nominal G6 period in clk cycles (fast-sim value).
- P_C7  24  nominal C7 period in clk cycles.
- P_E7  19  nominal E7 period in clk cycles.
- P_G7  16  nominal G7 period in clk cycles.
- TOL  1  accept window for each note is [P-TOL, P+TOL], inclusive. Windows must not overlap.
- MIN_PER  2  minimum run of consecutive same-note periods for a note to count.
- SIL_CYC  64  cycles with no rising edge that declare silence. Must exceed P_G6+TOL.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- piezo  in  1  raw piezo drive line (asynchronous to clk).
- note_vld  out  1  one-cycle pulse when a note is accepted.
- note  out  2  accepted note code: 0=G6, 1=C7, 2=E7, 3=G7. Held until the next note_vld.
- note_len  out  16  number of periods in the accepted note, saturating. Held with note.
- melody_vld  out  1  one-cycle pulse when a melody is closed.
- melody  out  2  melody code: 0=unknown, 1=steer, 2=fast, 3=batt. Held until the next melody_vld.
- busy  out  1  high while a melody is being collected (state TONE).

Behaviour:
- Reset is synchronous (rst sampled on the clk edge, active-high). All outputs reset to 0. The state machine goes to IDLE and all counters and buffers clear. A reset mid-melody discards everything collected so far and produces no pulse.
- Input path: piezo passes through a 2-flop synchronizer, then a rising-edge detector (rise). Input-to-rise latency is 3 cycles.
- Period counter per_cnt (16 bits, saturating):
  - Clears to 0 on rise.
  - Otherwise increments.
  - The period value is per_cnt+1, captured at rise.
  - Used only when a previous edge exists in the current burst.
- Classification: a period is valid for note N when it lies in [P_N-TOL, P_N+TOL]. Any other period is invalid.
- State IDLE:
  - busy=0.
  - The first rise moves the machine to TONE and arms the period counter.
  - No period is measured on this first edge.
- State TONE (busy=1), evaluated on each measured period:
  - Valid class equal to the current run note: run_cnt+1 (16 bits, saturating).
  - Valid class different from the run note:
    - If run_cnt >= MIN_PER, commit the old run.
    - Start a new run with the new note and run_cnt=1.
    - A commit and a new run start occur in the same cycle.
  - Invalid period:
    - Set err.
    - Commit the pending run if it qualifies.
    - Clear the run; the next valid period starts a new run.
  - Commit means:
    - note_vld=1 for the next cycle; note and note_len are updated.
    - The note is shifted into a 6-entry, 2-bit sequence buffer and seq_cnt is incremented.
    - A 7th commit sets ovf; seq_cnt saturates at 7.
  - Runs shorter than MIN_PER are dropped silently (glitch filter). They do not set err.
  - When per_cnt reaches SIL_CYC-1: commit the pending run if it qualifies, then go to EVAL.
- State EVAL (1 cycle):
  - Emit melody_vld, then return to IDLE.
  - Clear err, ovf, seq_cnt and the buffer.
  - If err or ovf is set, melody=0.
  - Otherwise the melody is matched exactly, oldest note first:
    - steer = G6 C7 E7 G7 E7 G7 (seq_cnt=6).
    - fast = G6 C7 E7 (seq_cnt=3).
    - batt = G7 E7 G7 E7 C7 G6 (seq_cnt=6).
    - Any other sequence, including seq_cnt=0, gives melody=0.
- Rise coincident with the silence threshold: silence wins. The rise is treated as the first edge of a new burst; the machine enters IDLE-equivalent with the counter armed.
- Total latency from the last piezo rising edge to melody_vld is 3+SIL_CYC+1 cycles.

Test Plan:
- Reset, piezo held low for 200 cycles -> all outputs 0, no pulses, busy=0.
- Steer melody: 8 periods each at 32, 24, 19, 16, 19, 16 cycles, then silence -> six note_vld pulses with note=0,1,2,3,2,3 and note_len=8. melody_vld occurs 68 cycles after the last edge, melody=1.
- Fast melody: 5 periods each at 31, 25, 18, then silence (edge-of-window values) -> notes 0,1,2, melody=2. Reversed batt order (16,19,16,19,24,32) -> melody=3.
- Steer melody with one 27-cycle period inside the C7 run -> note_vld still fires for the surrounding qualified runs, and melody=0 (err).
- Single 1-period G7 glitch between G6 and C7 runs -> no G7 note_vld (filtered), no err, and the sequence decodes normally.
- Assert rst mid-steer after 3 notes -> outputs 0 on the next cycle. A subsequent complete fast melody decodes as melody=2, and no stale melody_vld pulse occurs.

Source files
------------

// File: rtl/piezo_mon.sv
// Piezo alert-line decoder: measures square-wave periods, groups them into notes and
// identifies the melody (steer / fast / batt) once the line has been silent.
module piezo_mon #(
  parameter int unsigned P_G6    = 32,
  parameter int unsigned P_C7    = 24,
  parameter int unsigned P_E7    = 19,
  parameter int unsigned P_G7    = 16,
  parameter int unsigned TOL     = 1,
  parameter int unsigned MIN_PER = 2,
  parameter int unsigned SIL_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        piezo,
  output logic        note_vld,
  output logic [1:0]  note,
  output logic [15:0] note_len,
  output logic        melody_vld,
  output logic [1:0]  melody,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StTone, StEval} state_e;

  localparam logic [11:0] SeqSteer = {2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
  localparam logic [5:0]  SeqFast  = {2'd0, 2'd1, 2'd2};
  localparam logic [11:0] SeqBatt  = {2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

  state_e      state_q;
  logic [2:0]  sync_q;
  logic [15:0] per_cnt_q;
  logic [1:0]  run_note_q, run_note_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [11:0] seq_q;
  logic [2:0]  seq_cnt_q;
  logic        err_q, ovf_q, armed_q;

  logic        rise, silence, run_ok, commit, err_set, cls_vld;
  logic [1:0]  cls, mel_code;
  logic [31:0] period;

  function automatic logic in_win(input logic [31:0] per, input int unsigned nom);
    return (per + TOL >= nom) && (per <= nom + TOL);
  endfunction

  assign rise    = sync_q[1] & ~sync_q[2];
  assign period  = {16'd0, per_cnt_q} + 32'd1;
  assign silence = (per_cnt_q == 16'(SIL_CYC - 1));
  assign run_ok  = (run_cnt_q >= 16'(MIN_PER));
  assign busy    = (state_q == StTone);

  always_comb begin
    cls_vld = 1'b1;
    cls     = 2'd0;
    if (in_win(period, P_G6))      cls = 2'd0;
    else if (in_win(period, P_C7)) cls = 2'd1;
    else if (in_win(period, P_E7)) cls = 2'd2;
    else if (in_win(period, P_G7)) cls = 2'd3;
    else                           cls_vld = 1'b0;
  end

  // Run tracking; silence takes priority over a coincident rise.
  always_comb begin
    commit     = 1'b0;
    err_set    = 1'b0;
    run_note_d = run_note_q;
    run_cnt_d  = run_cnt_q;
    if (state_q == StTone) begin
      if (silence) begin
        commit    = run_ok;
        run_cnt_d = 16'd0;
      end else if (rise) begin
        if (!cls_vld) begin
          err_set   = 1'b1;
          commit    = run_ok;
          run_cnt_d = 16'd0;
        end else if (run_cnt_q != 16'd0 && cls == run_note_q) begin
          if (run_cnt_q != 16'hffff) run_cnt_d = run_cnt_q + 16'd1;
        end else begin
          commit     = run_ok;
          run_note_d = cls;
          run_cnt_d  = 16'd1;
        end
      end
    end
  end

  // Entry 0 of seq_q is the newest note, so the oldest sits in the highest slot in use.
  always_comb begin
    mel_code = 2'd0;
    if (!err_q && !ovf_q) begin
      if (seq_cnt_q == 3'd6 && seq_q == SeqSteer)     mel_code = 2'd1;
      else if (seq_cnt_q == 3'd3 && seq_q[5:0] == SeqFast) mel_code = 2'd2;
      else if (seq_cnt_q == 3'd6 && seq_q == SeqBatt) mel_code = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      per_cnt_q  <= '0;
      run_note_q <= '0;
      run_cnt_q  <= '0;
      seq_q      <= '0;
      seq_cnt_q  <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      armed_q    <= 1'b0;
      note_vld   <= 1'b0;
      note       <= '0;
      note_len   <= '0;
      melody_vld <= 1'b0;
      melody     <= '0;
    end else begin
      note_vld   <= 1'b0;
      melody_vld <= 1'b0;
      sync_q     <= {sync_q[1:0], piezo};
      run_note_q <= run_note_d;
      run_cnt_q  <= run_cnt_d;
      if (err_set) err_q <= 1'b1;
      if (commit) begin
        note_vld <= 1'b1;
        note     <= run_note_q;
        note_len <= run_cnt_q;
        seq_q    <= {seq_q[9:0], run_note_q};
        if (seq_cnt_q >= 3'd6) ovf_q <= 1'b1;
        if (seq_cnt_q != 3'd7) seq_cnt_q <= seq_cnt_q + 3'd1;
      end
      case (state_q)
        StIdle: begin
          per_cnt_q <= '0;
          if (rise) state_q <= StTone;
        end
        StTone: begin
          if (silence) begin
            state_q   <= StEval;
            per_cnt_q <= '0;
            armed_q   <= rise;
          end else if (rise) begin
            per_cnt_q <= '0;
          end else if (per_cnt_q != 16'hffff) begin
            per_cnt_q <= per_cnt_q + 16'd1;
          end
        end
        StEval: begin
          melody_vld <= 1'b1;
          melody     <= mel_code;
          err_q      <= 1'b0;
          ovf_q      <= 1'b0;
          seq_cnt_q  <= '0;
          seq_q      <= '0;
          armed_q    <= 1'b0;
          state_q    <= (armed_q || rise) ? StTone : StIdle;
          if (rise)         per_cnt_q <= '0;
          else if (armed_q) per_cnt_q <= per_cnt_q + 16'd1;
          else              per_cnt_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_mon.sv
// Bench for piezo_mon: table vectors, reset corner case and random bursts against a
// note/melody model computed directly from the list of driven periods.
module tb_piezo_mon;

  logic        clk = 1'b0;
  logic        rst, piezo;
  logic        note_vld, melody_vld, busy;
  logic [1:0]  note, melody;
  logic [15:0] note_len;

  piezo_mon dut (
    .clk(clk), .rst(rst), .piezo(piezo), .note_vld(note_vld), .note(note),
    .note_len(note_len), .melody_vld(melody_vld), .melody(melody), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct {
    int code;
    int len;
  } note_t;

  typedef struct {
    int nseg;
    int seg_p[8];
    int seg_n[8];
    int mel;
  } vec_t;

  note_t got_notes[$], exp_notes[$];
  int    got_mel[$], got_mel_cyc[$];
  int    pq[$];
  int    exp_mel, last_stamp;
  int    nominal[4] = '{32, 24, 19, 16};
  int    pat[3][6]  = '{'{0, 1, 2, 3, 2, 3}, '{0, 1, 2, 0, 0, 0}, '{3, 2, 3, 2, 1, 0}};
  int    pat_len[3] = '{6, 3, 6};
  vec_t  vecs[5];

  always @(negedge clk) begin
    if (note_vld) got_notes.push_back('{int'(note), int'(note_len)});
    if (melody_vld) begin
      got_mel.push_back(int'(melody));
      got_mel_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int classify(input int p);
    for (int n = 0; n < 4; n++) if (p >= nominal[n] - 1 && p <= nominal[n] + 1) return n;
    return -1;
  endfunction

  // Notes are runs of >=2 same-class periods; an invalid period poisons the melody.
  task automatic model();
    int    cur = -1, len = 0, c;
    bit    err = 0;
    string s = "";
    exp_notes.delete();
    foreach (pq[i]) begin
      c = classify(pq[i]);
      if (c < 0) begin
        err = 1;
        if (len >= 2) exp_notes.push_back('{cur, len});
        cur = -1;
        len = 0;
      end else if (c == cur) begin
        len++;
      end else begin
        if (len >= 2) exp_notes.push_back('{cur, len});
        cur = c;
        len = 1;
      end
    end
    if (len >= 2) exp_notes.push_back('{cur, len});
    foreach (exp_notes[i]) s = {s, $sformatf("%0d", exp_notes[i].code)};
    if (err || exp_notes.size() > 6) exp_mel = 0;
    else if (s == "012323") exp_mel = 1;
    else if (s == "012")    exp_mel = 2;
    else if (s == "323210") exp_mel = 3;
    else                    exp_mel = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // First rising edge, then one further rising edge per entry in pq; leaves piezo high.
  task automatic drive_edges();
    @(posedge clk);
    #2 piezo = 1'b1;
    foreach (pq[i]) begin
      wait_cycles(pq[i] / 2);
      piezo = 1'b0;
      wait_cycles(pq[i] - pq[i] / 2);
      piezo = 1'b1;
    end
    last_stamp = cyc;
  endtask

  task automatic run_burst(input string name, input int mel_override);
    int n;
    got_notes.delete();
    got_mel.delete();
    got_mel_cyc.delete();
    model();
    if (mel_override >= 0) exp_mel = mel_override;
    drive_edges();
    @(negedge clk);
    check({name, " busy in burst"}, int'(busy), 1);
    wait_cycles(2);
    piezo = 1'b0;
    for (int i = 0; i < 150 && got_mel.size() == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check({name, " melody_vld count"}, got_mel.size(), 1);
    if (got_mel.size() > 0) begin
      check({name, " melody"}, got_mel[0], exp_mel);
      check({name, " melody latency"}, got_mel_cyc[0] - last_stamp, 68);
    end
    check({name, " note count"}, got_notes.size(), exp_notes.size());
    n = (got_notes.size() < exp_notes.size()) ? got_notes.size() : exp_notes.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s note[%0d]", name, i), got_notes[i].code, exp_notes[i].code);
      check($sformatf("%s note_len[%0d]", name, i), got_notes[i].len, exp_notes[i].len);
    end
    check({name, " busy after"}, int'(busy), 0);
  endtask

  task automatic load_vec(input int v);
    pq.delete();
    for (int s = 0; s < vecs[v].nseg; s++)
      for (int k = 0; k < vecs[v].seg_n[s]; k++) pq.push_back(vecs[v].seg_p[s]);
  endtask

  task automatic push_note(input int n, input int len);
    for (int k = 0; k < len; k++) pq.push_back(nominal[n] + int'($urandom_range(0, 2)) - 1);
  endtask

  initial begin
    int p;
    vecs[0] = '{6, '{32, 24, 19, 16, 19, 16, 0, 0}, '{8, 8, 8, 8, 8, 8, 0, 0}, 1};
    vecs[1] = '{3, '{31, 25, 18, 0, 0, 0, 0, 0}, '{5, 5, 5, 0, 0, 0, 0, 0}, 2};
    vecs[2] = '{6, '{16, 19, 16, 19, 24, 32, 0, 0}, '{8, 8, 8, 8, 8, 8, 0, 0}, 3};
    vecs[3] = '{8, '{32, 24, 27, 24, 19, 16, 19, 16}, '{8, 4, 1, 3, 8, 8, 8, 8}, 0};
    vecs[4] = '{7, '{32, 16, 24, 19, 16, 19, 16, 0}, '{8, 1, 8, 8, 8, 8, 8, 0}, 1};

    rst = 1'b1;
    piezo = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;

    // Idle line: nothing may happen.
    got_notes.delete();
    got_mel.delete();
    repeat (200) @(negedge clk);
    check("idle note_vld count", got_notes.size(), 0);
    check("idle melody_vld count", got_mel.size(), 0);
    check("idle busy", int'(busy), 0);
    check("idle note", int'(note), 0);
    check("idle note_len", int'(note_len), 0);
    check("idle melody", int'(melody), 0);

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_burst($sformatf("vec%0d", v), vecs[v].mel);
      wait_cycles(20);
    end

    // Reset after three committed notes of a steer melody.
    pq.delete();
    for (int k = 0; k < 8; k++) pq.push_back(32);
    for (int k = 0; k < 8; k++) pq.push_back(24);
    for (int k = 0; k < 8; k++) pq.push_back(19);
    for (int k = 0; k < 4; k++) pq.push_back(16);
    got_notes.delete();
    got_mel.delete();
    drive_edges();
    wait_cycles(4);
    check("pre-reset note count", got_notes.size(), 3);
    rst = 1'b1;
    piezo = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset note", int'(note), 0);
    check("reset note_len", int'(note_len), 0);
    check("reset busy", int'(busy), 0);
    check("reset melody", int'(melody), 0);
    check("reset note_vld", int'(note_vld), 0);
    rst = 1'b0;
    got_notes.delete();
    got_mel.delete();
    repeat (120) @(negedge clk);
    check("post-reset stale melody_vld", got_mel.size(), 0);
    check("post-reset stale note_vld", got_notes.size(), 0);
    load_vec(1);
    run_burst("post-reset fast", 2);
    wait_cycles(20);

    // Random bursts: either a jittered known melody or arbitrary runs with some junk.
    for (int t = 0; t < 20; t++) begin
      pq.delete();
      if ($urandom_range(0, 2) == 0) begin
        int m = int'($urandom_range(0, 2));
        for (int i = 0; i < pat_len[m]; i++) push_note(pat[m][i], int'($urandom_range(2, 5)));
      end else begin
        int nruns = int'($urandom_range(1, 8));
        for (int r = 0; r < nruns; r++) begin
          if ($urandom_range(0, 9) == 0) begin
            do p = int'($urandom_range(4, 40)); while (classify(p) >= 0);
            pq.push_back(p);
          end else begin
            push_note(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
          end
        end
      end
      run_burst($sformatf("rand%0d", t), -1);
      wait_cycles(int'($urandom_range(1, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
